// File: rtl/reg_arb_pkg.sv
// Shared definitions for the register-bus arbiter: FSM state encodings and bus owner codes.
package reg_arb_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_QUIET  = 3'd1;
    localparam logic [2:0] ST_WR     = 3'd2;
    localparam logic [2:0] ST_WR_GAP = 3'd3;
    localparam logic [2:0] ST_RD     = 3'd4;
    localparam logic [2:0] ST_RD_CAP = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;
    localparam logic [2:0] ST_ABORT  = 3'd7;

    localparam logic OWNER_USB = 1'b0;
    localparam logic OWNER_INT = 1'b1;

endpackage

// File: rtl/reg_arb_idle_timer.sv
// Counts consecutive USB-idle cycles while enabled; expired marks the last required idle cycle.
module reg_arb_idle_timer #(
    parameter int pIDLE_CYCLES = 4
) (
    input  logic clk_usb,
    input  logic reset,
    input  logic usb_busy,
    input  logic enable,
    output logic expired
);

    localparam int CW = (pIDLE_CYCLES > 1) ? $clog2(pIDLE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(pIDLE_CYCLES - 1);

    logic [CW-1:0] count;

    assign expired = enable && !usb_busy && (count == LAST);

    // Any busy cycle restarts the quiet window from zero.
    always_ff @(posedge clk_usb) begin
        if (reset || !enable || usb_busy || expired)
            count <= '0;
        else
            count <= count + CW'(1);
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Shares the register bus between the USB front end (absolute priority) and an internal burst master.
// Optional statistics counters are built only when REG_ARB_STATS_EN is defined.
module reg_bus_arbiter
    import reg_arb_pkg::*;
#(
    parameter int pBYTECNT_SIZE = 7,
    parameter int pIDLE_CYCLES  = 4
) (
    input  logic                     clk_usb,
    input  logic                     reset,
    input  logic                     usb_busy,
    input  logic [7:0]               usb_reg_address,
    input  logic [pBYTECNT_SIZE-1:0] usb_reg_bytecnt,
    input  logic [7:0]               usb_reg_datao,
    input  logic                     usb_reg_read,
    input  logic                     usb_reg_write,
    output logic [7:0]               usb_reg_datai,
    input  logic                     int_req,
    input  logic                     int_we,
    input  logic [7:0]               int_addr,
    input  logic [pBYTECNT_SIZE-1:0] int_len,
    input  logic [7:0]               int_wdata,
    output logic                     int_wdata_ack,
    output logic [7:0]               int_rdata,
    output logic                     int_rdata_valid,
    output logic                     int_grant,
    output logic                     int_done,
    output logic                     int_abort,
    output logic [7:0]               reg_address,
    output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
    output logic [7:0]               reg_datao,
    input  logic [7:0]               reg_datai,
    output logic                     reg_read,
    output logic                     reg_write,
    output logic [15:0]              stat_grants,
    output logic [15:0]              stat_aborts
);

    logic [2:0]               state, next_state;
    logic [7:0]               lat_addr;
    logic [pBYTECNT_SIZE-1:0] lat_len, bytecnt, bytecnt_nxt;
    logic                     usb_act, owner, expired, last_byte, start_burst;

    assign usb_act     = usb_busy | usb_reg_read | usb_reg_write;
    assign owner       = (!usb_act && (state == ST_WR || state == ST_RD)) ? OWNER_INT : OWNER_USB;
    assign bytecnt_nxt = bytecnt + pBYTECNT_SIZE'(1);
    assign last_byte   = (bytecnt_nxt == lat_len);
    assign start_burst = (state == ST_QUIET) && expired && (int_len != '0);

    reg_arb_idle_timer #(.pIDLE_CYCLES(pIDLE_CYCLES)) u_idle_timer (
        .clk_usb  (clk_usb),
        .reset    (reset),
        .usb_busy (usb_busy),
        .enable   (state == ST_QUIET),
        .expired  (expired)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (int_req) next_state = ST_QUIET;
            ST_QUIET:  if (expired) next_state = (int_len == '0) ? ST_DONE : (int_we ? ST_WR : ST_RD);
            ST_WR:     next_state = usb_act ? ST_ABORT : ST_WR_GAP;
            ST_WR_GAP: next_state = usb_act ? ST_ABORT : (last_byte ? ST_DONE : ST_WR);
            ST_RD:     next_state = usb_act ? ST_ABORT : ST_RD_CAP;
            ST_RD_CAP: next_state = usb_act ? ST_ABORT : (last_byte ? ST_DONE : ST_RD);
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_usb) begin
        if (reset) begin
            state           <= ST_IDLE;
            bytecnt         <= '0;
            int_grant       <= 1'b0;
            int_rdata       <= '0;
            int_rdata_valid <= 1'b0;
        end else begin
            state           <= next_state;
            // Read data is taken while the internal read strobe is on the bus.
            int_rdata_valid <= (state == ST_RD) && !usb_act;
            if (state == ST_RD && !usb_act)
                int_rdata <= reg_datai;
            if (start_burst) begin
                bytecnt   <= '0;
                int_grant <= 1'b1;
            end else if ((state == ST_WR_GAP || state == ST_RD_CAP) && !usb_act) begin
                bytecnt <= bytecnt_nxt;
            end
            if (state == ST_DONE || state == ST_ABORT)
                int_grant <= 1'b0;
        end
    end

    always_ff @(posedge clk_usb) begin
        if (start_burst) begin
            lat_addr <= int_addr;
            lat_len  <= int_len;
        end
    end

    assign usb_reg_datai = reg_datai;
    assign reg_address   = (owner == OWNER_INT) ? lat_addr           : usb_reg_address;
    assign reg_bytecnt   = (owner == OWNER_INT) ? bytecnt            : usb_reg_bytecnt;
    assign reg_datao     = (owner == OWNER_INT) ? int_wdata          : usb_reg_datao;
    assign reg_read      = (owner == OWNER_INT) ? (state == ST_RD)   : usb_reg_read;
    assign reg_write     = (owner == OWNER_INT) ? (state == ST_WR)   : usb_reg_write;
    assign int_wdata_ack = (state == ST_WR) && !usb_act;
    assign int_done      = (state == ST_DONE);
    assign int_abort     = (state == ST_ABORT);

`ifdef REG_ARB_STATS_EN
    logic [15:0] grants_q, aborts_q;

    always_ff @(posedge clk_usb) begin
        if (reset) begin
            grants_q <= '0;
            aborts_q <= '0;
        end else begin
            if (start_burst && grants_q != 16'hFFFF)
                grants_q <= grants_q + 16'd1;
            if (next_state == ST_ABORT && state != ST_ABORT && aborts_q != 16'hFFFF)
                aborts_q <= aborts_q + 16'd1;
        end
    end

    assign stat_grants = grants_q;
    assign stat_aborts = aborts_q;
`else
    assign stat_grants = 16'h0000;
    assign stat_aborts = 16'h0000;
`endif

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter: write/read bursts, USB preemption, quiet restart, zero length, reset mid-burst.
module tb_reg_bus_arbiter;

    localparam int BC = 7;

    logic          clk_usb = 1'b0;
    logic          reset;
    logic          usb_busy, usb_reg_read, usb_reg_write;
    logic [7:0]    usb_reg_address, usb_reg_datao, usb_reg_datai;
    logic [BC-1:0] usb_reg_bytecnt;
    logic          int_req, int_we, int_wdata_ack, int_rdata_valid, int_grant, int_done, int_abort;
    logic [7:0]    int_addr, int_wdata, int_rdata;
    logic [BC-1:0] int_len;
    logic [7:0]    reg_address, reg_datao, reg_datai;
    logic [BC-1:0] reg_bytecnt;
    logic          reg_read, reg_write;
    logic [15:0]   stat_grants, stat_aborts;

    always #5 clk_usb = ~clk_usb;

    reg_bus_arbiter #(.pBYTECNT_SIZE(BC), .pIDLE_CYCLES(4)) dut (
        .clk_usb(clk_usb), .reset(reset), .usb_busy(usb_busy),
        .usb_reg_address(usb_reg_address), .usb_reg_bytecnt(usb_reg_bytecnt),
        .usb_reg_datao(usb_reg_datao), .usb_reg_read(usb_reg_read), .usb_reg_write(usb_reg_write),
        .usb_reg_datai(usb_reg_datai), .int_req(int_req), .int_we(int_we), .int_addr(int_addr),
        .int_len(int_len), .int_wdata(int_wdata), .int_wdata_ack(int_wdata_ack),
        .int_rdata(int_rdata), .int_rdata_valid(int_rdata_valid), .int_grant(int_grant),
        .int_done(int_done), .int_abort(int_abort), .reg_address(reg_address),
        .reg_bytecnt(reg_bytecnt), .reg_datao(reg_datao), .reg_datai(reg_datai),
        .reg_read(reg_read), .reg_write(reg_write), .stat_grants(stat_grants), .stat_aborts(stat_aborts)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-burst observation log, filled at the falling edge of every cycle.
    int   cyc_n, n_wr, n_rd, n_rv, n_ack, n_done, n_abort, first_grant, done_cyc, abort_cyc;
    int   wr_cyc[8], wr_bc[8], wr_dat[8], wr_adr[8], rd_cyc[8], rd_bc[8], rv_cyc[8], rv_dat[8];
    logic sv_ack, sv_rv, sv_done, sv_abort, sv_grant, sv_read;
    logic [7:0] sv_addr, sv_udatai;
    logic [7:0] wdata_q[4];
    int   widx;

    task automatic clear_mon();
        cyc_n = -1; n_wr = 0; n_rd = 0; n_rv = 0; n_ack = 0; n_done = 0; n_abort = 0;
        first_grant = -1; done_cyc = -1; abort_cyc = -1;
    endtask

    task automatic cyc();
        @(negedge clk_usb);
        cyc_n++;
        sv_ack = int_wdata_ack; sv_rv = int_rdata_valid; sv_done = int_done; sv_abort = int_abort;
        sv_grant = int_grant; sv_read = reg_read; sv_addr = reg_address; sv_udatai = usb_reg_datai;
        if (reg_write && n_wr < 8) begin
            wr_cyc[n_wr] = cyc_n; wr_bc[n_wr] = int'(reg_bytecnt);
            wr_dat[n_wr] = int'(reg_datao); wr_adr[n_wr] = int'(reg_address); n_wr++;
        end
        if (reg_read && n_rd < 8) begin
            rd_cyc[n_rd] = cyc_n; rd_bc[n_rd] = int'(reg_bytecnt); n_rd++;
        end
        if (int_rdata_valid && n_rv < 8) begin
            rv_cyc[n_rv] = cyc_n; rv_dat[n_rv] = int'(int_rdata); n_rv++;
        end
        if (int_wdata_ack) n_ack++;
        if (int_done) begin n_done++; done_cyc = cyc_n; end
        if (int_abort) begin n_abort++; abort_cyc = cyc_n; end
        if (int_grant && first_grant < 0) first_grant = cyc_n;
        @(posedge clk_usb);
        #1;
    endtask

    task automatic start(input logic we, input logic [7:0] addr, input int len);
        clear_mon();
        widx = 0; int_wdata = wdata_q[0];
        int_we = we; int_addr = addr; int_len = BC'(len); int_req = 1'b1;
    endtask

    // inj_kind: 1 = USB write strobe, 2 = usb_busy, applied during cycle inj_at.
    task automatic run_burst(input int bound, input int inj_kind, input int inj_at);
        logic ended;
        ended = 1'b0;
        for (int k = 0; k < bound && !ended; k++) begin
            cyc();
            if (sv_done || sv_abort) ended = 1'b1;
            if (sv_ack && widx < 3) begin widx++; int_wdata = wdata_q[widx]; end
            if (sv_rv) reg_datai = 8'hA5;
            usb_reg_write = (inj_kind == 1 && cyc_n + 1 == inj_at);
            usb_busy      = (inj_kind == 2 && cyc_n + 1 == inj_at);
        end
        check("burst_end", 32'(ended), 32'd1);
        int_req = 1'b0; usb_reg_write = 1'b0; usb_busy = 1'b0;
    endtask

    initial begin
        wdata_q[0] = 8'h11; wdata_q[1] = 8'h22; wdata_q[2] = 8'h33; wdata_q[3] = 8'h44;
        reset = 1'b1; usb_busy = 0; usb_reg_read = 0; usb_reg_write = 0;
        usb_reg_address = 8'h00; usb_reg_bytecnt = '0; usb_reg_datao = 8'h00;
        int_req = 0; int_we = 0; int_addr = 8'h00; int_len = '0; int_wdata = 8'h00; reg_datai = 8'h00;
        clear_mon();
        repeat (3) @(posedge clk_usb);
        #1;
        reset = 1'b0;

        // Reset state and USB pass-through while idle.
        usb_reg_address = 8'h99; usb_reg_read = 1'b1; reg_datai = 8'h3C;
        cyc();
        check("rst_grant", 32'(sv_grant), 32'd0);
        check("rst_done_abort", {sv_done, sv_abort}, 32'd0);
        check("rst_ack_valid", {sv_ack, sv_rv}, 32'd0);
        check("rst_rdata", 32'(int_rdata), 32'd0);
        check("rst_stats", {stat_grants, stat_aborts}, 32'd0);
        check("idle_usb_addr", 32'(sv_addr), 32'h99);
        check("idle_usb_read", 32'(sv_read), 32'd1);
        check("usb_datai", 32'(sv_udatai), 32'h3C);
        usb_reg_read = 1'b0; usb_reg_address = 8'h00;

        // Write burst, len 3: IDLE at 0, QUIET 1-4, WR at 5/7/9, DONE at 11.
        start(1'b1, 8'h2A, 3);
        run_burst(40, 0, -1);
        check("wr_grant_cyc", first_grant, 32'd5);
        check("wr_count", n_wr, 32'd3);
        check("wr_cycles", {wr_cyc[0][7:0], wr_cyc[1][7:0], wr_cyc[2][7:0]}, 32'h050709);
        check("wr_bytecnt", {wr_bc[0][7:0], wr_bc[1][7:0], wr_bc[2][7:0]}, 32'h000102);
        check("wr_data", {wr_dat[0][7:0], wr_dat[1][7:0], wr_dat[2][7:0]}, 32'h112233);
        check("wr_addr", wr_adr[2], 32'h2A);
        check("wr_done", {n_done[7:0], done_cyc[7:0]}, 32'h010B);
`ifdef REG_ARB_STATS_EN
        check("wr_stat_grants", 32'(stat_grants), 32'd1);
`endif
        cyc();
        check("wr_grant_drop", 32'(sv_grant), 32'd0);

        // Read burst, len 2: RD at 5/7, valid at 6/8, DONE at 9.
        reg_datai = 8'h5A;
        start(1'b0, 8'h40, 2);
        run_burst(40, 0, -1);
        check("rd_count", n_rd, 32'd2);
        check("rd_cycles", {rd_cyc[0][7:0], rd_cyc[1][7:0]}, 32'h0507);
        check("rd_bytecnt", {rd_bc[0][7:0], rd_bc[1][7:0]}, 32'h0001);
        check("rv_cycles", {n_rv[7:0], rv_cyc[0][7:0], rv_cyc[1][7:0]}, 32'h020608);
        check("rv_data", {rv_dat[0][7:0], rv_dat[1][7:0]}, 32'h5AA5);
        check("rd_done", {n_wr[7:0], done_cyc[7:0]}, 32'h0009);

        // Preemption: USB write lands on the second internal WR cycle (7).
        usb_reg_address = 8'h77; usb_reg_datao = 8'hC3; usb_reg_bytecnt = BC'(5);
        start(1'b1, 8'h30, 4);
        run_burst(40, 1, 7);
        check("pre_writes", n_wr, 32'd2);
        check("pre_int_write", {wr_adr[0][7:0], wr_dat[0][7:0]}, 32'h3011);
        check("pre_usb_pass", {wr_adr[1][7:0], wr_dat[1][7:0], wr_bc[1][7:0]}, 32'h77C305);
        check("pre_ack", n_ack, 32'd1);
        check("pre_abort", {n_abort[7:0], abort_cyc[7:0], n_done[7:0]}, 32'h010800);
`ifdef REG_ARB_STATS_EN
        check("pre_stats", {stat_grants, stat_aborts}, {16'd3, 16'd1});
`else
        check("pre_stats_off", {stat_grants, stat_aborts}, 32'd0);
`endif
        cyc();
        check("pre_grant_drop", 32'(sv_grant), 32'd0);
        usb_reg_address = 8'h00; usb_reg_datao = 8'h00; usb_reg_bytecnt = '0;

        // Quiet restart: busy at quiet count 3 (cycle 4) pushes grant from 5 to 9.
        start(1'b1, 8'h0F, 1);
        run_burst(40, 2, 4);
        check("qr_grant_cyc", first_grant, 32'd9);
        check("qr_write", {n_wr[7:0], wr_cyc[0][7:0]}, 32'h0109);
        check("qr_done", done_cyc, 32'd11);

        // Zero length: straight to DONE after the quiet window, no strobes, no grant.
        start(1'b1, 8'h50, 0);
        run_burst(40, 0, -1);
        check("z_strobes", {n_wr[7:0], n_rd[7:0]}, 32'd0);
        check("z_done", {n_done[7:0], done_cyc[7:0]}, 32'h0105);
        check("z_grant", first_grant, -1);

        // Reset during byte 1 of a 3-byte write.
        start(1'b1, 8'h55, 3);
        for (int k = 0; k < 8; k++) cyc();
        reset = 1'b1; int_req = 1'b0; usb_reg_address = 8'h12;
        cyc();
        reset = 1'b0;
        cyc();
        check("rs_grant", 32'(sv_grant), 32'd0);
        check("rs_ack_valid", {sv_ack, sv_rv}, 32'd0);
        check("rs_addr_usb", 32'(sv_addr), 32'h12);
        check("rs_rdata", 32'(int_rdata), 32'd0);
        check("rs_stats", {stat_grants, stat_aborts}, 32'd0);
        repeat (6) cyc();
        check("rs_writes", n_wr, 32'd2);
        check("rs_no_pulse", {n_done[7:0], n_abort[7:0]}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
